// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared types, default sizes and port-slicing helper for reg_bank_mp
package reg_bank_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_e;

    localparam int DEFAULT_BITS       = 8;
    localparam int DEFAULT_REG_SIZE   = 4;
    localparam int DEFAULT_READ_PORTS = 2;

    // Lowest bit of field 'port' inside a flattened bus of 'width'-bit fields
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_bank_clear_ctrl.sv
// rtl/reg_bank_clear_ctrl.sv - sequential bulk-clear engine: FSM, index counter, active flag
module reg_bank_clear_ctrl
    import reg_bank_pkg::*;
#(
    parameter int REG_SIZE = DEFAULT_REG_SIZE,
    parameter int AW       = $clog2(DEFAULT_REG_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    output logic          clear_active,
    output logic [AW-1:0] clear_index
);

    localparam logic [AW-1:0] LAST_INDEX = AW'(REG_SIZE - 1);

    clear_state_e  state;
    clear_state_e  state_next;
    logic [AW-1:0] count;
    logic [AW-1:0] count_next;

    // State and counter registers; reset aborts any clear in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Next state: one register zeroed per cycle, stop after the last index, requests ignored while clearing
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    count_next = '0;
                end
            end
            CLEAR: begin
                if (count == LAST_INDEX) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    assign clear_active = (state == CLEAR);
    assign clear_index  = count;

endmodule

// File: rtl/reg_bank_mp.sv
// rtl/reg_bank_mp.sv - multi-read-port register bank with bulk clear; REG_BANK_MP_BYPASS_EN enables write-to-read forwarding
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int  BITS       = DEFAULT_BITS,
    parameter int  REG_SIZE   = DEFAULT_REG_SIZE,
    parameter int  READ_PORTS = DEFAULT_READ_PORTS,
    localparam int AW         = $clog2(REG_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_enable,
    input  logic [AW-1:0]              write_address,
    input  logic [BITS-1:0]            write_data,
    input  logic [READ_PORTS*AW-1:0]   read_address,
    output logic [READ_PORTS*BITS-1:0] read_data,
    input  logic                       clear_req,
    output logic                       busy,
    output logic                       write_dropped
);

    // One extra bit so REG_SIZE itself is representable for range checks
    localparam logic [AW:0] REG_COUNT = (AW + 1)'(REG_SIZE);

    logic [BITS-1:0] regs [REG_SIZE];
    logic            clear_active;
    logic [AW-1:0]   clear_index;
    logic            write_in_range;
    logic            write_accept;

    reg_bank_clear_ctrl #(
        .REG_SIZE (REG_SIZE),
        .AW       (AW)
    ) u_clear_ctrl (
        .clk          (clk),
        .rst          (rst),
        .clear_req    (clear_req),
        .clear_active (clear_active),
        .clear_index  (clear_index)
    );

    assign write_in_range = ({1'b0, write_address} < REG_COUNT);
    assign write_accept   = write_enable & ~clear_active & write_in_range;
    assign busy           = clear_active;
    assign write_dropped  = write_enable & (clear_active | ~write_in_range);

    // Storage: clear engine owns the array while active, otherwise accepted writes land
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_SIZE; i++) begin
                regs[i] <= '0;
            end
        end else if (clear_active) begin
            regs[clear_index] <= '0;
        end else if (write_accept) begin
            regs[write_address] <= write_data;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [AW-1:0]   addr;
        logic [BITS-1:0] data;

        assign addr = read_address[port_lsb(p, AW) +: AW];

        // Per-port combinational read; out-of-range addresses return zero
        always_comb begin
            data = '0;
            if ({1'b0, addr} < REG_COUNT) begin
                data = regs[addr];
            end
`ifdef REG_BANK_MP_BYPASS_EN
            if (write_accept && (addr == write_address)) begin
                data = write_data;
            end
`else
`endif
        end

        assign read_data[port_lsb(p, BITS) +: BITS] = data;
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// tb/tb_reg_bank_mp.sv - self-checking bench for reg_bank_mp with a queue-based reference model
module tb_reg_bank_mp;

    logic clk = 1'b0;
    logic rst;
    logic rst8;

    always #5 clk = ~clk;

    // Main instance: 4 registers, 3 read ports
    logic        we, clr, busy, drop;
    logic [1:0]  wa;
    logic [7:0]  wd;
    logic [5:0]  ra;
    logic [23:0] rd;

    reg_bank_mp #(.BITS(8), .REG_SIZE(4), .READ_PORTS(3)) u_dut (
        .clk(clk), .rst(rst), .write_enable(we), .write_address(wa), .write_data(wd),
        .read_address(ra), .read_data(rd), .clear_req(clr), .busy(busy), .write_dropped(drop)
    );

    // Non-power-of-two instance: 5 registers, 2 read ports
    logic        we5, clr5, busy5, drop5;
    logic [2:0]  wa5;
    logic [7:0]  wd5;
    logic [5:0]  ra5;
    logic [15:0] rd5;

    reg_bank_mp #(.BITS(8), .REG_SIZE(5), .READ_PORTS(2)) u_dut5 (
        .clk(clk), .rst(rst), .write_enable(we5), .write_address(wa5), .write_data(wd5),
        .read_address(ra5), .read_data(rd5), .clear_req(clr5), .busy(busy5), .write_dropped(drop5)
    );

    // Larger instance for reset during a clear: 8 registers, 2 read ports
    logic        we8, clr8, busy8, drop8;
    logic [2:0]  wa8;
    logic [7:0]  wd8;
    logic [5:0]  ra8;
    logic [15:0] rd8;

    reg_bank_mp #(.BITS(8), .REG_SIZE(8), .READ_PORTS(2)) u_dut8 (
        .clk(clk), .rst(rst8), .write_enable(we8), .write_address(wa8), .write_data(wd8),
        .read_address(ra8), .read_data(rd8), .clear_req(clr8), .busy(busy8), .write_dropped(drop8)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: register contents plus the list of indices a clear still has to zero
    logic [7:0] m_regs [4];
    int         m_clear_q [$];

    function automatic bit m_busy();
        return m_clear_q.size() != 0;
    endfunction

    function automatic bit m_accept();
        return we && !m_busy() && (int'(wa) < 4);
    endfunction

    function automatic logic [7:0] m_read(input int a);
        logic [7:0] v;
        v = (a < 4) ? m_regs[a] : 8'h00;
`ifdef REG_BANK_MP_BYPASS_EN
        if (m_accept() && a == int'(wa)) v = wd;
`endif
        return v;
    endfunction

    // Check every output against the model, then advance one clock edge in both
    task automatic step();
        #2;
        for (int p = 0; p < 3; p++) begin
            check($sformatf("rd%0d", p), {24'h0, rd[p*8 +: 8]}, {24'h0, m_read(int'(ra[p*2 +: 2]))});
        end
        check("busy", {31'h0, busy}, {31'h0, m_busy()});
        check("dropped", {31'h0, drop}, {31'h0, we && (m_busy() || int'(wa) >= 4)});
        @(posedge clk);
        if (m_busy()) begin
            m_regs[m_clear_q.pop_front()] = 8'h00;
        end else begin
            if (m_accept()) m_regs[wa] = wd;
            if (clr) m_clear_q = '{0, 1, 2, 3};
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w_en, input int a, input int d, input bit c);
        we  = w_en;
        wa  = 2'(a);
        wd  = 8'(d);
        clr = c;
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2);
        ra = {2'(a2), 2'(a1), 2'(a0)};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        logic [7:0] byp_exp;

        rst = 1'b1; rst8 = 1'b1;
        drive(0, 0, 0, 0); set_ra(0, 0, 0);
        we5 = 0; wa5 = 0; wd5 = 0; ra5 = 0; clr5 = 0;
        we8 = 0; wa8 = 0; wd8 = 0; ra8 = 0; clr8 = 0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        // Reset state visible while reset is held
        for (int a = 0; a < 4; a++) begin
            set_ra(a, a, a);
            #1;
            check($sformatf("rst_rd_a%0d", a), {8'h0, rd}, 32'h0);
        end
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_drop", {31'h0, drop}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; rst8 = 1'b0;
        set_ra(0, 1, 2);
        step();
        set_ra(3, 3, 3);
        step();

        // Basic writes and multi-port reads
        drive(1, 2, 'hA5, 0); step();
        drive(1, 1, 'h3C, 0); step();
        drive(0, 0, 0, 0); set_ra(2, 1, 2);
        #1;
        check("wr_p0", {24'h0, rd[7:0]},   32'hA5);
        check("wr_p1", {24'h0, rd[15:8]},  32'h3C);
        check("wr_p2", {24'h0, rd[23:16]}, 32'hA5);
        step();

        // Same-cycle read of the register being written
        drive(1, 2, 'h77, 0); set_ra(2, 2, 2);
        #1;
`ifdef REG_BANK_MP_BYPASS_EN
        byp_exp = 8'h77;
`else
        byp_exp = 8'hA5;
`endif
        check("same_cycle_rd", {24'h0, rd[7:0]}, {24'h0, byp_exp});
        step();
        drive(0, 0, 0, 0);
        step();

        // Bulk clear with a one-cycle request
        for (int i = 0; i < 4; i++) begin
            drive(1, i, 'h11 * (i + 1), 0);
            step();
        end
        drive(0, 0, 0, 1); step();
        drive(0, 0, 0, 0);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (busy) cnt++;
            if (c == 2) begin
                set_ra(0, 2, 3);
                #1;
                check("mid_clr_r0", {24'h0, rd[7:0]},   32'h00);
                check("mid_clr_r2", {24'h0, rd[15:8]},  32'h33);
                check("mid_clr_r3", {24'h0, rd[23:16]}, 32'h44);
                set_ra(1, 1, 1);
                #1;
                check("mid_clr_r1", {24'h0, rd[7:0]}, 32'h00);
            end
            step();
        end
        check("clr_busy_cycles", cnt, 4);
        for (int a = 0; a < 4; a++) begin
            set_ra(a, a, a);
            #1;
            check($sformatf("post_clr_a%0d", a), {8'h0, rd}, 32'h0);
        end

        // Write and repeated request while clearing
        for (int i = 0; i < 4; i++) begin
            drive(1, i, 'h5 + i, 0);
            step();
        end
        drive(0, 0, 0, 1); step();
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) drive(1, 3, 'hFF, 1);
            else drive(0, 0, 0, 0);
            #1;
            if (busy) cnt++;
            if (c == 1) check("drop_in_clr", {31'h0, drop}, 32'h1);
            step();
        end
        check("repulse_busy_cycles", cnt, 4);
        set_ra(3, 3, 3);
        #1;
        check("reg3_after_clr", {24'h0, rd[7:0]}, 32'h00);

        // Clear request held high across the return to idle
        drive(0, 0, 0, 1);
        for (int c = 0; c < 10; c++) step();
        drive(0, 0, 0, 0);
        for (int c = 0; c < 6; c++) step();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
                  $urandom_range(0, 15) == 0);
            ra = 6'($urandom);
            step();
        end
        drive(0, 0, 0, 0);
        for (int c = 0; c < 5; c++) step();

        // Out-of-range protection on the 5-register instance
        for (int i = 0; i < 5; i++) begin
            we5 = 1; wa5 = 3'(i); wd5 = 8'(8'h50 + i);
            #1;
            check($sformatf("r5_inrange_drop%0d", i), {31'h0, drop5}, 32'h0);
            tick();
        end
        we5 = 1; wa5 = 3'd6; wd5 = 8'hEE;
        #1;
        check("r5_oor_drop", {31'h0, drop5}, 32'h1);
        tick();
        we5 = 0;
        for (int a = 0; a < 5; a++) begin
            ra5 = {3'(a), 3'(a)};
            #1;
            check($sformatf("r5_keep%0d", a), {24'h0, rd5[7:0]}, 32'h50 + a);
        end
        ra5 = {3'd5, 3'd7};
        #1;
        check("r5_rd7", {24'h0, rd5[7:0]},  32'h0);
        check("r5_rd5", {24'h0, rd5[15:8]}, 32'h0);

        // Reset in the third clear cycle of the 8-register instance
        for (int i = 0; i < 8; i++) begin
            we8 = 1; wa8 = 3'(i); wd8 = 8'(8'h80 + i);
            tick();
        end
        we8 = 0; clr8 = 1;
        tick();
        clr8 = 0;
        tick();
        tick();
        check("r8_busy_before_rst", {31'h0, busy8}, 32'h1);
        #1;
        rst8 = 1'b1;
        #1;
        check("r8_busy_in_rst", {31'h0, busy8}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            ra8 = {3'(a), 3'(a)};
            #1;
            check($sformatf("r8_rst_rd%0d", a), {16'h0, rd8}, 32'h0);
        end
        @(posedge clk); #1;
        rst8 = 1'b0;
        we8 = 1; wa8 = 3'd5; wd8 = 8'h5A;
        #1;
        check("r8_wr_after_rst_drop", {31'h0, drop8}, 32'h0);
        tick();
        we8 = 0; ra8 = {3'd0, 3'd5};
        #1;
        check("r8_rd5", {24'h0, rd8[7:0]},  32'h5A);
        check("r8_rd0", {24'h0, rd8[15:8]}, 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
